pcunit: RTL and testbench
=========================

# pcunit

Program-counter and control-flow stage that consumes the flag register's 8-bit output alongside the decoded instruction fields. It holds the PC, resolves conditional branches against the current flags, and runs a small interrupt entry/return state machine gated by the I flag. Its `pc` output addresses instruction memory; decode supplies `i`, `s`, `val` and `target` on the same cycle.

## Interface
Parameters:
- `PCW`, 8, PC and target width in bits.
- `IVEC`, 8'hF0, interrupt vector address (PCW bits).

Ports:
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `i`  input  5  instruction opcode.
- `s`  input  3  flag selector for BRF (bit index into `flags`).
- `val`  input  1  required flag value for BRF.
- `target`  input  PCW  branch/jump destination.
- `flags`  input  8  flag register output (Z0 O1 N2 C3 I4 A5).
- `irq`  input  1  level interrupt request.
- `stall`  input  1  hold all state this cycle.
- `pc`  output  PCW  current program counter.
- `in_isr`  output  1  high while in ISR state.
- `irq_ack`  output  1  one-cycle pulse on interrupt entry.

## Operation
- Opcodes handled:
  - 5'h1B BRF: branch if `flags[s] == val`.
  - 5'h1C JMP: unconditional.
  - 5'h1D RETI: return from interrupt.
  - All other opcodes: `pc <= pc + 1`.
- BRF condition:
  - s = 0..5 selects `flags[s]`; taken → `pc <= target`, not taken → `pc <= pc + 1`.
  - s = 6 or 7: never taken.
  - s = 5, val = 1 (A flag) is always taken.
- JMP: `pc <= target`.
- States: RUN, ISR. Reset → RUN.
- RUN → ISR when `irq && flags[4] && !stall`:
  - `epc <= pc`, `pc <= IVEC`, `irq_ack <= 1`.
  - The instruction present that cycle is discarded. It re-executes after RETI because `epc` holds its address.
- In ISR:
  - `irq` is ignored; no nesting.
  - BRF and JMP behave normally.
  - RETI: `pc <= epc`, state → RUN.
- RETI in RUN: treated as a no-op (`pc + 1`).
- Priority in RUN: interrupt entry > branch/jump/sequential.
- `stall` high: `pc`, `epc` and state hold; `irq_ack` forced 0; no interrupt is taken.
- PC arithmetic is modulo 2^PCW; `pc + 1` wraps from all-ones to 0.

## Timing
- Registered outputs. All updates occur on the rising edge after the inputs are sampled; latency is 1 cycle.
- Reset values: `pc = 0`, `epc = 0`, state RUN, `in_isr = 0`, `irq_ack = 0`. Reset overrides `stall`, `irq` and every opcode. Reset while in ISR returns the block to RUN with `pc = 0`.
- `irq_ack` is high for exactly the one cycle in which `pc == IVEC` first appears. It is registered together with the state change.
- `in_isr` rises in the same cycle as `irq_ack` and falls in the cycle `pc` shows the restored `epc`.
- `flags` are sampled combinationally in the current cycle. A flag-writing instruction therefore affects a BRF only in a later cycle, because the flag register updates on the edge.
- An `irq` that is still asserted when RETI completes is taken on the next unstalled RUN cycle if I = 1. This means at least one RUN cycle at `epc` is presented before re-entry.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_BRF, OP_JMP, OP_RETI;
  - flag index constants F_Z, F_O, F_N, F_C, F_I, F_A;
  - enum `pcstate_t` {RUN, ISR}.
- One sub-module, `branchcond`: combinational evaluation of (`flags`, `s`, `val`) → `taken`.
- PC, `epc`, state and `irq_ack` registers live in `pcunit` itself.

## Test plan
- Reset, then 3 cycles with `i = 5'h00` → `pc` goes 0, 1, 2, 3. Reset asserted mid-run → `pc = 0` on the next edge.
- BRF, `flags = 8'h21`, `s = 0`, `val = 1`, `target = 8'h40` → `pc = 8'h40`. Same with `val = 0` → `pc + 1`. `s = 6` → `pc + 1`.
- JMP to 8'hFF, then a NOP → `pc` 8'hFF then wraps to 8'h00.
- At `pc = 8'h10`, `irq = 1`, `flags[4] = 1`, `i = BRF` (taken) → branch ignored, `pc = 8'hF0`, `irq_ack` pulse of 1 cycle, `in_isr = 1`. Second irq in ISR → ignored. RETI → `pc = 8'h10`, `in_isr = 0`.
- `irq = 1` with `flags[4] = 0` → no entry. `irq = 1`, I = 1, `stall = 1` for 3 cycles → `pc` held, no ack. Entry occurs on the first unstalled cycle.
- RETI while in RUN at `pc = 8'h05` → `pc = 8'h06`, state stays RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, flag bit positions and the control-flow state type.
package cpu_pkg;

    localparam logic [4:0] OP_BRF  = 5'h1B;
    localparam logic [4:0] OP_JMP  = 5'h1C;
    localparam logic [4:0] OP_RETI = 5'h1D;

    localparam logic [2:0] F_Z = 3'd0;
    localparam logic [2:0] F_O = 3'd1;
    localparam logic [2:0] F_N = 3'd2;
    localparam logic [2:0] F_C = 3'd3;
    localparam logic [2:0] F_I = 3'd4;
    localparam logic [2:0] F_A = 3'd5;

    typedef enum logic [0:0] {
        RUN = 1'b0,
        ISR = 1'b1
    } pcstate_t;

endpackage

// File: rtl/pcunit_branchcond.sv
// Combinational BRF condition: compares the selected flag against the required value.
module branchcond
    import cpu_pkg::*;
(
    input  logic [7:0] flags,
    input  logic [2:0] s,
    input  logic       val,
    output logic       taken
);

    // Selectors 6 and 7 name no flag and never branch; A with val=1 always branches.
    always_comb begin
        taken = 1'b0;
        case (s)
            F_Z, F_O, F_N, F_C, F_I: taken = (flags[s] == val);
            F_A:                     taken = val | ~flags[F_A];
            default:                 taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pcunit.sv
// Program counter with conditional branch, jump, and single-level interrupt entry/return.
module pcunit
    import cpu_pkg::*;
#(
    parameter int unsigned         PCW  = 8,
    parameter logic [PCW-1:0]      IVEC = 8'hF0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     i,
    input  logic [2:0]     s,
    input  logic           val,
    input  logic [PCW-1:0] target,
    input  logic [7:0]     flags,
    input  logic           irq,
    input  logic           stall,
    output logic [PCW-1:0] pc,
    output logic           in_isr,
    output logic           irq_ack
);

    localparam logic [PCW-1:0] PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
    localparam logic [PCW-1:0] PC_ZERO = {PCW{1'b0}};

    pcstate_t       state_r;
    logic [PCW-1:0] epc_r;
    logic [PCW-1:0] next_pc_s;
    logic           taken_s;

    branchcond u_branchcond (
        .flags (flags),
        .s     (s),
        .val   (val),
        .taken (taken_s)
    );

    // Normal-flow next PC; RETI falls through to pc+1 here and is resolved in ISR below.
    always_comb begin
        next_pc_s = pc + PC_ONE;
        case (i)
            OP_BRF: begin
                if (taken_s) begin
                    next_pc_s = target;
                end else begin
                    next_pc_s = pc + PC_ONE;
                end
            end
            OP_JMP:  next_pc_s = target;
            default: next_pc_s = pc + PC_ONE;
        endcase
    end

    // PC, saved PC, state and the interrupt handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= PC_ZERO;
            epc_r   <= PC_ZERO;
            state_r <= RUN;
            in_isr  <= 1'b0;
            irq_ack <= 1'b0;
        end else if (stall) begin
            irq_ack <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (irq && flags[F_I]) begin
                        // The instruction at pc is dropped; epc makes it re-execute after RETI.
                        epc_r   <= pc;
                        pc      <= IVEC;
                        state_r <= ISR;
                        in_isr  <= 1'b1;
                        irq_ack <= 1'b1;
                    end else begin
                        pc      <= next_pc_s;
                        irq_ack <= 1'b0;
                    end
                end
                ISR: begin
                    irq_ack <= 1'b0;
                    if (i == OP_RETI) begin
                        pc      <= epc_r;
                        state_r <= RUN;
                        in_isr  <= 1'b0;
                    end else begin
                        pc      <= next_pc_s;
                    end
                end
                default: begin
                    pc      <= PC_ZERO;
                    state_r <= RUN;
                    in_isr  <= 1'b0;
                    irq_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcunit.sv
// Directed vector table followed by randomized traffic checked against a behavioural model.
module tb_pcunit;

    logic       clk;
    logic       reset;
    logic [4:0] i;
    logic [2:0] s;
    logic       val;
    logic [7:0] target;
    logic [7:0] flags;
    logic       irq;
    logic       stall;
    logic [7:0] pc;
    logic       in_isr;
    logic       irq_ack;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_pc;
    int m_epc;
    bit m_isr;
    bit m_ack;

    pcunit #(.PCW(8), .IVEC(8'hF0)) dut (
        .clk     (clk),
        .reset   (reset),
        .i       (i),
        .s       (s),
        .val     (val),
        .target  (target),
        .flags   (flags),
        .irq     (irq),
        .stall   (stall),
        .pc      (pc),
        .in_isr  (in_isr),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit [4:0] op;
        bit [2:0] sel;
        bit       v;
        bit [7:0] tgt;
        bit [7:0] fl;
        bit       rq;
        bit       stl;
        bit [7:0] e_pc;
        bit       e_isr;
        bit       e_ack;
    } vec_t;

    vec_t vecs[$];

    // Control-flow rules stated directly: reset, stall, interrupt entry, RETI, branches.
    task automatic model_step();
        bit cond;
        if (reset) begin
            m_pc = 0; m_epc = 0; m_isr = 0; m_ack = 0;
        end else if (stall) begin
            m_ack = 0;
        end else if (!m_isr && irq && flags[4]) begin
            m_epc = m_pc; m_pc = 240; m_isr = 1; m_ack = 1;
        end else begin
            m_ack = 0;
            cond = (s < 3'd6) && ((flags[s] == val) || (s == 3'd5 && val));
            if (m_isr && i == 5'h1D) begin
                m_pc = m_epc; m_isr = 0;
            end else if ((i == 5'h1B && cond) || i == 5'h1C) begin
                m_pc = target;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; i = v.op; s = v.sel; val = v.v;
        target = v.tgt; flags = v.fl; irq = v.rq; stall = v.stl;
    endtask

    function automatic vec_t mk(bit rst, bit [4:0] op, bit [2:0] sel, bit v, bit [7:0] tgt,
                                bit [7:0] fl, bit rq, bit stl, bit [7:0] e_pc, bit e_isr, bit e_ack);
        vec_t r;
        r.rst = rst; r.op = op; r.sel = sel; r.v = v; r.tgt = tgt; r.fl = fl;
        r.rq = rq; r.stl = stl; r.e_pc = e_pc; r.e_isr = e_isr; r.e_ack = e_ack;
        return r;
    endfunction

    initial begin
        vec_t v;
        //              rst op     sel   v     tgt    flags  irq   stl   pc     isr   ack
        vecs.push_back(mk(1'b1, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1B, 3'd0, 1'b1, 8'h40, 8'h21, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1B, 3'd0, 1'b0, 8'h40, 8'h21, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1B, 3'd6, 1'b1, 8'h40, 8'hFF, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1B, 3'd5, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1C, 3'd0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1C, 3'd0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0));
        // Interrupt entry beats a taken branch
        vecs.push_back(mk(1'b0, 5'h1B, 3'd0, 1'b1, 8'h40, 8'h31, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'hF1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1D, 3'd0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 5'h1D, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1D, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 3'd0, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 5'h1C, 3'd0, 1'b0, 8'h77, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1C, 3'd0, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'h1D, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'h1C, 3'd0, 1'b0, 8'h55, 8'h10, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0));

        drive(mk(1'b1, 5'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
        m_pc = 0; m_epc = 0; m_isr = 0; m_ack = 0;

        foreach (vecs[k]) begin
            v = vecs[k];
            drive(v);
            model_step();
            @(posedge clk); #1;
            check($sformatf("vec%0d pc", k), pc, v.e_pc);
            check($sformatf("vec%0d in_isr", k), in_isr, v.e_isr);
            check($sformatf("vec%0d irq_ack", k), irq_ack, v.e_ack);
        end

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(63) == 0);
            case ($urandom_range(4))
                0: i = 5'h1B;
                1: i = 5'h1C;
                2: i = 5'h1D;
                3: i = 5'h1B;
                default: i = 5'($urandom);
            endcase
            s = 3'($urandom);
            val = 1'($urandom);
            target = 8'($urandom);
            flags = 8'($urandom);
            irq = ($urandom_range(3) == 0);
            stall = ($urandom_range(7) == 0);
            model_step();
            @(posedge clk); #1;
            check($sformatf("rnd%0d pc", n), pc, m_pc);
            check($sformatf("rnd%0d in_isr", n), in_isr, m_isr);
            check($sformatf("rnd%0d irq_ack", n), irq_ack, m_ack);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
